// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the upstream producer, pipe_ctrl and the downstream consumer.
// The slave modport is the pipeline's view; master is the producer/consumer side.
interface pipe_ctrl_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Linear pipeline controller: per-stage valid/payload registers with stall, flush,
// downstream back-pressure and saturating stall/flush performance counters.
module pipe_ctrl #(
  parameter int STAGES = 5,
  parameter int WIDTH  = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  pipe_ctrl_if.slave        bus,
  input  logic [STAGES-1:0] stall_req,
  input  logic [STAGES-1:0] flush_req,
  output logic [STAGES-1:0] stage_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0][WIDTH-1:0]  data_q, data_d;
  logic [CNT_W-1:0]              stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0]              flushCnt_q, flushCnt_d;

  logic [STAGES-1:0] flushEff;
  logic [STAGES-1:0] kill;
  logic [STAGES-1:0] effStall;
  logic [STAGES-1:0] hold;
  logic              killIn;
  logic              inReady;
  logic              outBlocked;

  // Kill flows toward younger stages, hold flows toward younger stages from any staller.
  always_comb begin : hazard
    logic killAcc;
    logic holdAcc;
    flushEff = flush_req & valid_q;
    killIn   = |flushEff;
    killAcc  = 1'b0;
    kill     = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      kill[i] = killAcc;
      killAcc = killAcc | flushEff[i];
    end
    effStall   = stall_req & valid_q & ~kill;
    outBlocked = valid_q[STAGES-1] & ~bus.out_ready;
    holdAcc    = outBlocked;
    hold       = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      holdAcc = holdAcc | effStall[i];
      hold[i] = holdAcc;
    end
    inReady = ~hold[0] & ~killIn;
  end

  always_comb begin : nextState
    valid_d = valid_q;
    data_d  = data_q;
    if (kill[0]) begin
      valid_d[0] = 1'b0;
    end else if (!hold[0]) begin
      valid_d[0] = bus.in_valid & inReady;
      data_d[0]  = bus.in_data;
    end
    // A stalled predecessor feeding a free stage leaves a bubble behind it.
    for (int i = 1; i < STAGES; i++) begin
      if (kill[i]) begin
        valid_d[i] = 1'b0;
      end else if (!hold[i]) begin
        valid_d[i] = valid_q[i-1] & ~effStall[i-1];
        data_d[i]  = data_q[i-1];
      end
    end

    stallCnt_d = stallCnt_q;
    if (bus.in_valid && !inReady && !(&stallCnt_q)) begin
      stallCnt_d = stallCnt_q + CntOne;
    end
    flushCnt_d = flushCnt_q;
    if (killIn && !(&flushCnt_q)) begin
      flushCnt_d = flushCnt_q + CntOne;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      data_q     <= '0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = valid_q[STAGES-1] & ~effStall[STAGES-1];
  assign bus.out_data  = data_q[STAGES-1];
  assign stage_valid   = valid_q;
  assign stall_cnt     = stallCnt_q;
  assign flush_cnt     = flushCnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: fixed vector table, directed corner sequences,
// then randomized traffic compared against an index-based reference model.
module tb_pipe_ctrl;

  localparam int S    = 5;
  localparam int W    = 16;
  localparam int C    = 4;
  localparam int CMAX = (1 << C) - 1;

  logic          clock;
  logic          reset;
  logic [S-1:0]  stallReq;
  logic [S-1:0]  flushReq;
  logic [S-1:0]  stageValid;
  logic [C-1:0]  stallCnt;
  logic [C-1:0]  flushCnt;

  pipe_ctrl_if #(.WIDTH(W)) bus ();

  pipe_ctrl #(.STAGES(S), .WIDTH(W), .CNT_W(C)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .stall_req   (stallReq),
    .flush_req   (flushReq),
    .stage_valid (stageValid),
    .stall_cnt   (stallCnt),
    .flush_cnt   (flushCnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nChecks = 0;
  int nFail   = 0;

  // Reference model state: one slot per stage, counters as plain integers.
  bit           mV[S];
  logic [W-1:0] mD[S];
  int           mStall;
  int           mFlush;
  int           oldestFlush;
  int           topStall;
  bit           outBlocked;
  bit           eInReady;
  bit           eOutValid;

  typedef struct {
    logic         inValid;
    logic [W-1:0] inData;
    logic         expInReady;
    logic         expOutValid;
    logic [W-1:0] expOutData;
    logic [S-1:0] expStageValid;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [W-1:0] id,
                               input logic [S-1:0] st, input logic [S-1:0] fl,
                               input logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = id;
    stallReq      = st;
    flushReq      = fl;
    bus.out_ready = ordy;
  endtask

  task automatic modelReset();
    for (int i = 0; i < S; i++) begin
      mV[i] = 1'b0;
      mD[i] = '0;
    end
    mStall = 0;
    mFlush = 0;
  endtask

  // The oldest valid flusher kills everything below it; the oldest surviving staller holds everything at or below it.
  task automatic modelEval();
    oldestFlush = -1;
    topStall    = -1;
    for (int j = 0; j < S; j++)
      if (flushReq[j] && mV[j]) oldestFlush = j;
    for (int i = 0; i < S; i++)
      if (stallReq[i] && mV[i] && i >= oldestFlush) topStall = i;
    outBlocked = mV[S-1] && !bus.out_ready;
    eInReady   = !(outBlocked || topStall >= 0) && oldestFlush < 0;
    eOutValid  = mV[S-1] && topStall != S - 1;
  endtask

  task automatic modelStep();
    bit           nV[S];
    logic [W-1:0] nD[S];
    bit           prevStalled;
    modelEval();
    for (int i = 0; i < S; i++) begin
      nV[i] = mV[i];
      nD[i] = mD[i];
      if (i < oldestFlush) begin
        nV[i] = 1'b0;
      end else if (!(outBlocked || i <= topStall)) begin
        if (i == 0) begin
          nV[0] = bus.in_valid && eInReady;
          nD[0] = bus.in_data;
        end else begin
          prevStalled = stallReq[i-1] && mV[i-1] && (i - 1) >= oldestFlush;
          nV[i] = mV[i-1] && !prevStalled;
          nD[i] = mD[i-1];
        end
      end
    end
    if (bus.in_valid && !eInReady && mStall < CMAX) mStall++;
    if (oldestFlush >= 0 && mFlush < CMAX) mFlush++;
    mV = nV;
    mD = nD;
  endtask

  task automatic checkOutput();
    logic [S-1:0] sv;
    modelEval();
    for (int i = 0; i < S; i++) sv[i] = mV[i];
    check("in_ready", bus.in_ready, eInReady);
    check("out_valid", bus.out_valid, eOutValid);
    check("out_data", bus.out_data, mD[S-1]);
    check("stage_valid", stageValid, sv);
    check("stall_cnt", stallCnt, mStall);
    check("flush_cnt", flushCnt, mFlush);
  endtask

  task automatic preEdge(input logic iv, input logic [W-1:0] id,
                         input logic [S-1:0] st, input logic [S-1:0] fl, input logic ordy);
    applyStimulus(iv, id, st, fl, ordy);
    #2;
    checkOutput();
  endtask

  task automatic postEdge();
    modelStep();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, '0, '0, '0, 1'b1);
    reset = 1'b1;
    #2;
    modelReset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic fill(input logic [W-1:0] base);
    for (int k = 0; k < S; k++) begin
      preEdge(1'b1, base + W'(k), '0, '0, 1'b1);
      postEdge();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] heldData;
    logic [S-1:0] st;
    logic [S-1:0] fl;

    vecs[0] = '{1'b1, 16'h000A, 1'b1, 1'b0, 16'h0000, 5'b00000};
    vecs[1] = '{1'b1, 16'h000B, 1'b1, 1'b0, 16'h0000, 5'b00001};
    vecs[2] = '{1'b1, 16'h000C, 1'b1, 1'b0, 16'h0000, 5'b00011};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 5'b00111};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 5'b01110};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h000A, 5'b11100};
    vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h000B, 5'b11000};
    vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h000C, 5'b10000};
    vecs[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 5'b00000};

    applyStimulus(1'b0, '0, '0, '0, 1'b1);
    reset = 1'b1;
    modelReset();
    #2;
    check("reset stage_valid", stageValid, 5'b00000);
    check("reset out_valid", bus.out_valid, 1'b0);
    check("reset in_ready", bus.in_ready, 1'b1);
    check("reset stall_cnt", stallCnt, 0);
    check("reset flush_cnt", flushCnt, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Plain streaming: three back-to-back payloads, five-cycle residency.
    for (int r = 0; r < 9; r++) begin
      applyStimulus(vecs[r].inValid, vecs[r].inData, '0, '0, 1'b1);
      #2;
      check($sformatf("vec%0d in_ready", r), bus.in_ready, vecs[r].expInReady);
      check($sformatf("vec%0d out_valid", r), bus.out_valid, vecs[r].expOutValid);
      check($sformatf("vec%0d out_data", r), bus.out_data, vecs[r].expOutData);
      check($sformatf("vec%0d stage_valid", r), stageValid, vecs[r].expStageValid);
      postEdge();
    end

    // Stage 2 stall for three cycles on a full pipe.
    doReset();
    fill(16'h0100);
    for (int k = 0; k < 3; k++) begin
      preEdge(1'b1, 16'h0200, 5'b00100, '0, 1'b1);
      check("stall2 in_ready", bus.in_ready, 1'b0);
      postEdge();
    end
    check("stall2 stage_valid", stageValid, 5'b00111);
    check("stall2 stall_cnt", stallCnt, 3);

    // Flush from stage 3 on a full pipe.
    doReset();
    fill(16'h0001);
    preEdge(1'b1, 16'h0006, '0, 5'b01000, 1'b1);
    check("flush3 in_ready", bus.in_ready, 1'b0);
    postEdge();
    check("flush3 young stages", stageValid[2:0], 3'b000);
    check("flush3 stage4 valid", stageValid[4], 1'b1);
    check("flush3 advanced data", bus.out_data, 16'h0002);
    check("flush3 flush_cnt", flushCnt, 1);
    preEdge(1'b0, '0, '0, '0, 1'b1);
    postEdge();

    // Stall and flush together: the stall below the flusher is dropped.
    doReset();
    fill(16'h0020);
    preEdge(1'b1, 16'h0030, 5'b00010, 5'b01000, 1'b1);
    check("stall+flush in_ready", bus.in_ready, 1'b0);
    postEdge();
    check("stall+flush stage_valid", stageValid, 5'b11000);

    // Downstream back-pressure for two cycles, then drain in order.
    doReset();
    fill(16'h0010);
    for (int k = 0; k < 2; k++) begin
      preEdge(1'b1, 16'h0040, '0, '0, 1'b0);
      check("bp in_ready", bus.in_ready, 1'b0);
      check("bp out_data", bus.out_data, 16'h0010);
      postEdge();
    end
    for (int k = 0; k < S; k++) begin
      preEdge(1'b0, '0, '0, '0, 1'b1);
      check($sformatf("drain%0d out_valid", k), bus.out_valid, 1'b1);
      check($sformatf("drain%0d out_data", k), bus.out_data, 16'h0010 + W'(k));
      postEdge();
    end

    // Counter saturation, then asynchronous reset between clock edges.
    doReset();
    for (int k = 0; k < 20; k++) begin
      preEdge(1'b1, 16'h0300 + W'(k), 5'b00001, '0, 1'b1);
      postEdge();
    end
    check("sat stall_cnt", stallCnt, CMAX);
    #1;
    reset = 1'b1;
    #1;
    check("async stage_valid", stageValid, 5'b00000);
    check("async out_valid", bus.out_valid, 1'b0);
    check("async out_data", bus.out_data, 16'h0000);
    check("async stall_cnt", stallCnt, 0);
    check("async flush_cnt", flushCnt, 0);
    check("async in_ready", bus.in_ready, 1'b1);
    modelReset();
    @(posedge clock);
    #1;
    check("no capture in reset", stageValid, 5'b00000);
    reset = 1'b0;
    preEdge(1'b1, 16'h0055, '0, '0, 1'b1);
    postEdge();
    for (int k = 0; k < S - 1; k++) begin
      preEdge(1'b0, '0, '0, '0, 1'b1);
      postEdge();
    end
    preEdge(1'b0, '0, '0, '0, 1'b1);
    check("post-reset latency valid", bus.out_valid, 1'b1);
    check("post-reset latency data", bus.out_data, 16'h0055);
    postEdge();

    // Randomized traffic against the reference model.
    doReset();
    for (int n = 0; n < 500; n++) begin
      st = '0;
      fl = '0;
      for (int i = 0; i < S; i++) begin
        st[i] = ($urandom_range(7) == 0);
        fl[i] = ($urandom_range(19) == 0);
      end
      heldData = W'($urandom);
      preEdge($urandom_range(3) != 0, heldData, st, fl, $urandom_range(4) != 0);
      postEdge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 5, number of pipeline stages (legal range 2..8).
REQ-002 SHALL have parameter WIDTH, default 64, per-stage payload width in bits.
REQ-003 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-004 SHALL use one clock; reset is asynchronous and active-high; ports are named clock and reset.
REQ-005 Ports (name  direction  width  meaning):
  clock  in  1  rising-edge clock
  reset  in  1  async active-high reset
  in_valid  in  1  upstream offers payload to stage 0
  in_data  in  WIDTH  upstream payload
  in_ready  out  1  stage 0 accepts this cycle
  stall_req  in  STAGES  bit i: stage i requests hold
  flush_req  in  STAGES  bit i: stage i redirects and kills all younger entries
  out_valid  out  1  last stage presents payload
  out_data  out  WIDTH  last-stage payload
  out_ready  in  1  downstream accepts
  stage_valid  out  STAGES  valid bit of every stage
  stall_cnt  out  CNT_W  cycles with in_valid && !in_ready
  flush_cnt  out  CNT_W  cycles with any effective flush

Function
REQ-006 SHALL hold per stage i a valid bit v[i] and payload d[i]; stage 0 is youngest, stage STAGES-1 oldest.
REQ-007 SHALL compute flush_eff[j] = flush_req[j] && v[j]; flush_req on an invalid stage SHALL be ignored.
REQ-008 SHALL compute kill[i] = OR of flush_eff[j] for all j > i; kill_in = OR of all flush_eff.
REQ-009 SHALL compute eff_stall[i] = stall_req[i] && v[i] && !kill[i] (a stall from a stage being flushed is dropped).
REQ-010 SHALL compute hold[i] = OR of eff_stall[j] for j >= i, OR (v[STAGES-1] && !out_ready).
REQ-011 in_ready SHALL equal !hold[0] && !kill_in; combinational, no dependence on in_valid.
REQ-012 out_valid SHALL equal v[STAGES-1] && !eff_stall[STAGES-1]; out_data SHALL equal d[STAGES-1].
REQ-013 Stage 0 next state: kill[0] -> v[0]<=0; else !hold[0] -> v[0]<=in_valid && in_ready, d[0]<=in_data; else unchanged.
REQ-014 Stage i>0 next state: kill[i] -> v[i]<=0; else !hold[i] -> v[i]<=v[i-1] && !eff_stall[i-1], d[i]<=d[i-1]; else unchanged.
REQ-015 A stalled stage i with !hold[i+1] SHALL insert a bubble (v[i+1]<=0) into stage i+1 on the same edge.
REQ-016 The flushing stage j itself SHALL NOT be invalidated; it advances or holds per REQ-014.
REQ-017 Simultaneous flush_eff on several stages: union of kills; oldest requester dominates.
REQ-018 Zero-latency passthrough SHALL NOT exist: an accepted payload reaches out_valid exactly STAGES-1 cycles after acceptance when no hold/kill occurs (STAGES cycles of residency).
REQ-019 stall_cnt SHALL increment by 1 each cycle in_valid && !in_ready, saturating at all-ones.
REQ-020 flush_cnt SHALL increment by 1 each cycle kill_in is true, saturating at all-ones.
REQ-021 Payload registers of invalid stages SHALL still load per REQ-013/014 (no data gating); only v governs validity.

Reset
REQ-022 On reset assertion, immediately and independent of clock: all v=0, all d=0, stall_cnt=0, flush_cnt=0; hence out_valid=0, stage_valid=0.
REQ-023 in_ready SHALL be 1 during reset when out_ready=1 and no flush/stall (all v=0); no payload SHALL be captured while reset is high.
REQ-024 Reset mid-operation SHALL discard all in-flight entries; first accepted payload after deassertion follows REQ-018.

Verification
REQ-025 STAGES=5: inject 0xA,0xB,0xC on consecutive cycles, all stalls/flushes 0, out_ready=1 -> out_valid with 0xA,0xB,0xC on cycles 4,5,6 after first accept.
REQ-026 Stage 2 stall_req held 3 cycles with stages 0..4 full -> stages 0..2 frozen, stage 3 receives 3 bubbles, in_ready=0, stall_cnt+=3 with in_valid=1.
REQ-027 flush_req[3] pulse with stages 0..4 valid -> next cycle v[0..2]=0, stage 3 entry advances to stage 4, in_ready=0 during pulse, flush_cnt=1.
REQ-028 stall_req[1] and flush_req[3] same cycle -> stall dropped, stage 1 killed, no bubble counted in hold.
REQ-029 out_ready=0 for 2 cycles, pipe full -> all stages hold, out_data stable, no loss; release -> drain in order.
REQ-030 CNT_W=4, in_valid=1, stall_req[0]=1 for 20 cycles with v[0]=1 -> stall_cnt saturates at 15; async reset mid-run -> all outputs zero before next clock edge.
